// File: rtl/rcpu_mem_loader.sv
// Streams a big-endian word image into RAM through a write port and holds the CPU in reset until the load finishes.
// Optional trailing XOR checksum byte is enabled with `define RCPU_LOADER_CHECKSUM_EN.
module rcpu_mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] wrAddr,
  output logic [15:0] wrData,
  output logic        wrEn,
  output logic        cpuRst,
  output logic        done,
  output logic        err
);

`ifdef RCPU_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_CNT_HI  = 3'd0,
    S_CNT_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_FLUSH   = 3'd4,
    S_DONE    = 3'd5,
    S_CSUM    = 3'd6,
    S_ERR     = 3'd7
  } state_t;
  // Image end goes through the checksum byte instead of the flush cycle.
  localparam state_t S_AFTER_DATA = S_CSUM;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  typedef enum logic [2:0] {
    S_CNT_HI  = 3'd0,
    S_CNT_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_FLUSH   = 3'd4,
    S_DONE    = 3'd5
  } state_t;
  localparam state_t S_AFTER_DATA = S_FLUSH;
`endif

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wren_q, wren_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic        cpurst_q;
  logic        done_q;
  logic        ready;
  logic        xfer;

`ifdef RCPU_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        err_q;
`endif

  assign xfer = inValid && ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CNT_HI;
      addr_q   <= BASE_ADDR;
      wdata_q  <= 16'h0000;
      wren_q   <= 1'b0;
      cnt_q    <= 16'h0000;
      hi_q     <= 8'h00;
      cpurst_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef RCPU_LOADER_CHECKSUM_EN
      xor_q    <= 8'h00;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wren_q   <= wren_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      cpurst_q <= (state_d != S_DONE);
      done_q   <= (state_d == S_DONE);
`ifdef RCPU_LOADER_CHECKSUM_EN
      xor_q    <= xor_d;
      err_q    <= (state_d == S_ERR);
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CNT_HI: begin
        if (xfer) state_d = S_CNT_LO;
        else      state_d = state_q;
      end
      S_CNT_LO: begin
        if (xfer) begin
          if ({cnt_q[15:8], inData} != 16'h0000) state_d = S_DATA_HI;
          else                                   state_d = S_AFTER_DATA;
        end else begin
          state_d = state_q;
        end
      end
      S_DATA_HI: begin
        if (xfer) state_d = S_DATA_LO;
        else      state_d = state_q;
      end
      S_DATA_LO: begin
        if (xfer) begin
          if (cnt_q == 16'd1) state_d = S_AFTER_DATA;
          else                state_d = S_DATA_HI;
        end else begin
          state_d = state_q;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
`ifdef RCPU_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          if (inData == xor_q) state_d = S_DONE;
          else                 state_d = S_ERR;
        end else begin
          state_d = state_q;
        end
      end
      S_ERR: state_d = S_ERR;
`endif
      default: state_d = S_CNT_HI;
    endcase
  end

  // Word assembly, write strobe, address and counter updates.
  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    if (wren_q) addr_d = addr_q + 16'd1;
    else        addr_d = addr_q;
    if (xfer) begin
      case (state_q)
        S_CNT_HI:  cnt_d = {inData, cnt_q[7:0]};
        S_CNT_LO:  cnt_d = {cnt_q[15:8], inData};
        S_DATA_HI: hi_d  = inData;
        S_DATA_LO: begin
          wdata_d = {hi_q, inData};
          wren_d  = 1'b1;
          cnt_d   = cnt_q - 16'd1;
        end
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

`ifdef RCPU_LOADER_CHECKSUM_EN
  // Running XOR over the count and data bytes.
  always_comb begin
    if (xfer && (state_q inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO})) xor_d = xor_fold(xor_q, inData);
    else                                                                     xor_d = xor_q;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Stream ready decode.
  always_comb begin
    case (state_q)
      S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO: ready = 1'b1;
`ifdef RCPU_LOADER_CHECKSUM_EN
      S_CSUM: ready = 1'b1;
`endif
      default: ready = 1'b0;
    endcase
  end

  assign inReady = ready;
  assign wrAddr  = addr_q;
  assign wrData  = wdata_q;
  assign wrEn    = wren_q;
  assign cpuRst  = cpurst_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rcpu_mem_loader.sv
// Directed bench for rcpu_mem_loader: two instances (BASE_ADDR 0 and 16'hFFFF) share one stream.
module tb_rcpu_mem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        rdy0, we0, crst0, done0, err0;
  logic [15:0] wa0, wd0;
  logic        rdy1, we1, crst1, done1, err1;
  logic [15:0] wa1, wd1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wq[$];
  logic [31:0] fq[$];
  int          xfers = 0;
  int          crst_drops = 0;
  logic        watch = 1'b0;
  int          wbase, fbase, xbase;

  always #5 clk = ~clk;

  rcpu_mem_loader #(.BASE_ADDR(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .inData(in_data), .inValid(in_valid), .inReady(rdy0),
    .wrAddr(wa0), .wrData(wd0), .wrEn(we0), .cpuRst(crst0), .done(done0), .err(err0)
  );

  rcpu_mem_loader #(.BASE_ADDR(16'hFFFF)) u_dut_ff (
    .clk(clk), .rst(rst), .inData(in_data), .inValid(in_valid), .inReady(rdy1),
    .wrAddr(wa1), .wrData(wd1), .wrEn(we1), .cpuRst(crst1), .done(done1), .err(err1)
  );

  always @(negedge clk) begin
    if (we0) wq.push_back({wa0, wd0});
    if (we1) fq.push_back({wa1, wd1});
    if (watch && !crst0) crst_drops++;
  end

  always @(posedge clk) begin
    if (!rst && in_valid && rdy0) xfers++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'd0, rdy0},  32'd1);
    chk("rst_addr",   {16'd0, wa0},   32'h0000_0000);
    chk("rst_addr_ff",{16'd0, wa1},   32'h0000_FFFF);
    chk("rst_data",   {16'd0, wd0},   32'h0000_0000);
    chk("rst_flags",  {27'd0, we0, crst0, done0, err0, 1'b0}, {27'd0, 5'b01000});
    rst = 1'b0;

`ifndef RCPU_LOADER_CHECKSUM_EN
    // Full-rate two-word load.
    wbase = wq.size();
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
    idle();
    chk("t1_we_last",   {31'd0, we0},   32'd1);
    chk("t1_addr_last", {16'd0, wa0},   32'h0000_0001);
    chk("t1_data_last", {16'd0, wd0},   32'h0000_ABCD);
    chk("t1_not_done",  {30'd0, done0, crst0}, 32'd1);
    idle();
    chk("t1_done",      {29'd0, done0, crst0, rdy0}, 32'd4);
    chk("t1_we_off",    {31'd0, we0},   32'd0);
    chk("t1_nwrites",   wq.size() - wbase, 32'd2);
    chk("t1_w0",        wq[wbase],     32'h0000_1234);
    chk("t1_w1",        wq[wbase + 1], 32'h0001_ABCD);
    repeat (3) idle();
    chk("t1_hold",      {29'd0, done0, crst0, rdy0}, 32'd4);

    // Empty image.
    do_reset();
    wbase = wq.size();
    send(8'h00, 0); send(8'h00, 0);
    idle();
    chk("t2_flush",     {30'd0, done0, rdy0}, 32'd0);
    idle();
    chk("t2_done",      {30'd0, done0, crst0}, 32'd2);
    chk("t2_nwrites",   wq.size() - wbase, 32'd0);

    // Stalled stream, three idle cycles before every byte.
    do_reset();
    wbase = wq.size();
    xbase = xfers;
    send(8'h00, 3); send(8'h02, 3); send(8'h12, 3);
    send(8'h34, 3); send(8'hAB, 3); send(8'hCD, 3);
    idle();
    idle();
    chk("t3_done",      {31'd0, done0}, 32'd1);
    chk("t3_xfers",     xfers - xbase, 32'd6);
    chk("t3_nwrites",   wq.size() - wbase, 32'd2);
    chk("t3_w0",        wq[wbase],     32'h0000_1234);
    chk("t3_w1",        wq[wbase + 1], 32'h0001_ABCD);

    // Address wrap on the FFFF-based instance.
    do_reset();
    fbase = fq.size();
    send(8'h00, 0); send(8'h02, 0); send(8'h11, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h22, 1);
    idle();
    idle();
    chk("t4_nwrites",   fq.size() - fbase, 32'd2);
    chk("t4_w0",        fq[fbase],     32'hFFFF_1111);
    chk("t4_w1",        fq[fbase + 1], 32'h0000_2222);
    chk("t4_done",      {31'd0, done1}, 32'd1);

    // Reset after the first word of a three-word load, then a fresh one-word image.
    do_reset();
    watch = 1'b1;
    send(8'h00, 0); send(8'h03, 0); send(8'h01, 0); send(8'h02, 0);
    idle();
    idle();
    chk("t5_addr_pre",  {16'd0, wa0}, 32'h0000_0001);
    do_reset();
    chk("t5_addr_rst",  {16'd0, wa0}, 32'h0000_0000);
    chk("t5_crst_rst",  {31'd0, crst0}, 32'd1);
    wbase = wq.size();
    send(8'h00, 0); send(8'h01, 0); send(8'h55, 0); send(8'hAA, 0);
    idle();
    watch = 1'b0;
    idle();
    chk("t5_crst_held", crst_drops, 32'd0);
    chk("t5_done",      {30'd0, done0, crst0}, 32'd2);
    chk("t5_nwrites",   wq.size() - wbase, 32'd1);
    chk("t5_w0",        wq[wbase], 32'h0000_55AA);
`else
    // Good checksum: 00^01^12^34 = 27.
    do_reset();
    wbase = wq.size();
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h27, 0);
    idle();
    chk("c1_done",      {29'd0, done0, err0, crst0}, 32'd4);
    chk("c1_nwrites",   wq.size() - wbase, 32'd1);
    chk("c1_w0",        wq[wbase], 32'h0000_1234);

    // Bad checksum parks in the error state.
    do_reset();
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h26, 0);
    idle();
    for (int i = 0; i < 20; i++) begin
      chk("c2_err", {28'd0, err0, done0, crst0, rdy0}, 32'd10);
      idle();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
